// File: rtl/octal_ram_cfg_seq_if.sv
// Sequencer <-> config table / OctalRAM controller signal bundle.
// The master modport is the sequencer view; slave is the table/controller view.
interface octal_ram_cfg_seq_if;
    logic       iStart;
    logic [7:0] oNo;
    logic [7:0] iRegAddr;
    logic [7:0] iRegData;
    logic       oCmdValid;
    logic       oCmdWr;
    logic [7:0] oCmdAddr;
    logic [7:0] oCmdData;
    logic       iCmdReady;
    logic       iRdValid;
    logic [7:0] iRdData;
    logic       oRbValid;
    logic [7:0] oRbAddr;
    logic [7:0] oRbData;
    logic       oBusy;
    logic       oDone;
    logic       oErr;
    logic       oMismatch;

    modport master (
        input  iStart, iRegAddr, iRegData, iCmdReady, iRdValid, iRdData,
        output oNo, oCmdValid, oCmdWr, oCmdAddr, oCmdData,
               oRbValid, oRbAddr, oRbData, oBusy, oDone, oErr, oMismatch
    );

    modport slave (
        output iStart, iRegAddr, iRegData, iCmdReady, iRdValid, iRdData,
        input  oNo, oCmdValid, oCmdWr, oCmdAddr, oCmdData,
               oRbValid, oRbAddr, oRbData, oBusy, oDone, oErr, oMismatch
    );
endinterface

// File: rtl/octal_ram_cfg_seq.sv
// OctalRAM power-up configuration sequencer: walks the mode-register table issuing
// MRW/MRR commands, reports MRR read-backs and flags mismatches against this run's writes.
module octal_ram_cfg_seq #(
    parameter int unsigned WR_CNT       = 4,
    parameter int unsigned RD_CNT       = 6,
    parameter int unsigned PWRUP_CYCLES = 16,
    parameter int unsigned RD_TIMEOUT   = 255
) (
    input logic                 iClk,
    input logic                 iRst,
    octal_ram_cfg_seq_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PWRUP   = 3'd1;
    localparam logic [2:0] S_LOOKUP  = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAIT_RD = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    localparam logic [7:0]  LAST_NO  = 8'(WR_CNT + RD_CNT - 1);
    localparam logic [7:0]  WR_LIM   = 8'(WR_CNT);
    localparam logic [7:0]  RD_LAST  = 8'(RD_TIMEOUT);
    localparam logic [15:0] PWR_LAST = 16'(PWRUP_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  no_q, no_d;
    logic [15:0] pwr_cnt_q, pwr_cnt_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic        rb_valid_q, rb_valid_d;
    logic [7:0]  rb_addr_q, rb_addr_d;
    logic [7:0]  rb_data_q, rb_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mismatch_q, mismatch_d;

    logic [7:0]        sh_addr_q [WR_CNT];
    logic [7:0]        sh_addr_d [WR_CNT];
    logic [7:0]        sh_data_q [WR_CNT];
    logic [7:0]        sh_data_d [WR_CNT];
    logic [WR_CNT-1:0] sh_vld_q, sh_vld_d;

    logic       sh_hit;
    logic [7:0] sh_hit_data;
    logic       advance;

    // Lowest valid shadow entry whose address matches the outstanding MRR.
    always_comb begin
        sh_hit      = 1'b0;
        sh_hit_data = '0;
        for (int unsigned i = 0; i < WR_CNT; i++) begin
            if (!sh_hit && sh_vld_q[i] && (sh_addr_q[i] == cmd_addr_q)) begin
                sh_hit      = 1'b1;
                sh_hit_data = sh_data_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        no_d        = no_q;
        pwr_cnt_d   = pwr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        rb_valid_d  = 1'b0;
        rb_addr_d   = rb_addr_q;
        rb_data_d   = rb_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        mismatch_d  = mismatch_q;
        sh_addr_d   = sh_addr_q;
        sh_data_d   = sh_data_q;
        sh_vld_d    = sh_vld_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.iStart) begin
                    state_d    = S_PWRUP;
                    no_d       = '0;
                    pwr_cnt_d  = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    mismatch_d = 1'b0;
                    sh_vld_d   = '0;
                end
            end
            S_PWRUP: begin
                if (pwr_cnt_q == PWR_LAST) state_d = S_LOOKUP;
                else                       pwr_cnt_d = pwr_cnt_q + 16'd1;
            end
            S_LOOKUP: begin
                state_d     = S_ISSUE;
                cmd_valid_d = 1'b1;
                cmd_wr_d    = (no_q < WR_LIM);
                cmd_addr_d  = bus.iRegAddr;
                cmd_data_d  = (no_q < WR_LIM) ? bus.iRegData : '0;
            end
            S_ISSUE: begin
                if (bus.iCmdReady) begin
                    cmd_valid_d = 1'b0;
                    if (cmd_wr_q) begin
                        for (int unsigned i = 0; i < WR_CNT; i++) begin
                            if (no_q == 8'(i)) begin
                                sh_addr_d[i] = cmd_addr_q;
                                sh_data_d[i] = cmd_data_q;
                                sh_vld_d[i]  = 1'b1;
                            end
                        end
                        advance = 1'b1;
                    end else begin
                        state_d  = S_WAIT_RD;
                        rd_cnt_d = '0;
                    end
                end
            end
            S_WAIT_RD: begin
                if (bus.iRdValid) begin
                    rb_valid_d = 1'b1;
                    rb_addr_d  = cmd_addr_q;
                    rb_data_d  = bus.iRdData;
                    if (sh_hit && (sh_hit_data != bus.iRdData)) mismatch_d = 1'b1;
                    advance = 1'b1;
                end else if (rd_cnt_q == RD_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The NEXT step is folded into the completing edge, so each MRW costs LOOKUP+ISSUE only.
        if (advance) begin
            if (no_q == LAST_NO) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                no_d    = no_q + 8'd1;
                state_d = S_LOOKUP;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            no_q        <= '0;
            pwr_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            rb_valid_q  <= 1'b0;
            rb_addr_q   <= '0;
            rb_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mismatch_q  <= 1'b0;
            sh_vld_q    <= '0;
        end else begin
            state_q     <= state_d;
            no_q        <= no_d;
            pwr_cnt_q   <= pwr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            rb_valid_q  <= rb_valid_d;
            rb_addr_q   <= rb_addr_d;
            rb_data_q   <= rb_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mismatch_q  <= mismatch_d;
            sh_vld_q    <= sh_vld_d;
        end
    end

    // Shadow payload is qualified by sh_vld_q, so it needs no reset.
    always_ff @(posedge iClk) begin
        sh_addr_q <= sh_addr_d;
        sh_data_q <= sh_data_d;
    end

    assign bus.oNo       = no_q;
    assign bus.oCmdValid = cmd_valid_q;
    assign bus.oCmdWr    = cmd_wr_q;
    assign bus.oCmdAddr  = cmd_addr_q;
    assign bus.oCmdData  = cmd_data_q;
    assign bus.oRbValid  = rb_valid_q;
    assign bus.oRbAddr   = rb_addr_q;
    assign bus.oRbData   = rb_data_q;
    assign bus.oBusy     = busy_q;
    assign bus.oDone     = done_q;
    assign bus.oErr      = err_q;
    assign bus.oMismatch = mismatch_q;
endmodule

// File: tb/tb_octal_ram_cfg_seq.sv
// Scoreboard bench for octal_ram_cfg_seq: models the config table and a controller,
// queues expected commands and read-backs, and compares them as the DUT produces them.
module tb_octal_ram_cfg_seq;
    localparam int unsigned WR_CNT       = 4;
    localparam int unsigned RD_CNT       = 6;
    localparam int unsigned PWRUP_CYCLES = 16;
    localparam int unsigned RD_TIMEOUT   = 255;
    localparam int unsigned N_ENT        = WR_CNT + RD_CNT;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    octal_ram_cfg_seq_if bus ();

    octal_ram_cfg_seq #(
        .WR_CNT      (WR_CNT),
        .RD_CNT      (RD_CNT),
        .PWRUP_CYCLES(PWRUP_CYCLES),
        .RD_TIMEOUT  (RD_TIMEOUT)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus)
    );

    logic [7:0] tbl_a [N_ENT] = '{8'h00, 8'h04, 8'h06, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08};
    logic [7:0] tbl_d [N_ENT] = '{8'h08, 8'h40, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] mem [256];

    logic [16:0] exp_cmd [$];
    logic [15:0] exp_rb  [$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    int          last_hs  = 0;

    int         rd_delay = 1;
    bit         slow_en = 0;   logic [7:0] slow_addr = '0; int slow_delay = 1;
    bit         bad_en = 0;    logic [7:0] bad_addr = '0;  logic [7:0] bad_data = '0;
    bit         drop_en = 0;   logic [7:0] drop_addr = '0;
    bit         hold_en = 0;   int hold_left = 0;
    bit         stray_wr_en = 0, stray_hs_en = 0, mid_start_en = 0;
    bit         start_req = 0, rst_req = 0, ghost = 0, chk_drop = 0;
    bit         rd_pending = 0; int rd_wait = 0; logic [7:0] rd_addr = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int base_lat(input int d);
        return PWRUP_CYCLES + 2 * WR_CNT + RD_CNT * (2 + d) + 1;
    endfunction

    // One clock of table + controller model + monitor, all evaluated at the falling edge.
    task automatic step();
        logic       hs;
        logic [7:0] rdata;
        int         idx;
        @(negedge iClk);
        cyc++;
        if (chk_drop) check_eq("cmd_drop", 64'(bus.oCmdValid), 64'd0);
        chk_drop = 0;

        iRst = rst_req;
        rst_req = 0;
        if (iRst) ghost = 1;
        bus.iStart = start_req;
        start_req = 0;

        idx = int'(bus.oNo);
        bus.iRegAddr = (idx < int'(N_ENT)) ? tbl_a[idx] : 8'h00;
        bus.iRegData = (idx < int'(N_ENT)) ? tbl_d[idx] : 8'h00;

        bus.iCmdReady = 1'b1;
        if (hold_en && bus.oCmdValid && (bus.oNo == 8'd2) && hold_left > 0) begin
            bus.iCmdReady = 1'b0;
            hold_left--;
            check_eq("hold_stable", {47'd0, bus.oCmdWr, bus.oCmdAddr, bus.oCmdData}, {47'd0, 1'b1, 8'h06, 8'hF0});
        end
        hs = bus.oCmdValid && bus.iCmdReady && !iRst;

        bus.iRdValid = 1'b0;
        bus.iRdData  = 8'h00;
        if (rd_pending) begin
            rd_wait--;
            if (rd_wait == 0) begin
                rd_pending = 0;
                rdata = (bad_en && rd_addr == bad_addr) ? bad_data : mem[rd_addr];
                bus.iRdValid = 1'b1;
                bus.iRdData  = rdata;
                if (!ghost) exp_rb.push_back({rd_addr, rdata});
            end
        end
        if (stray_wr_en && bus.oCmdValid && bus.oCmdWr) begin
            bus.iRdValid = 1'b1;
            bus.iRdData  = 8'hA5;
        end
        if (stray_hs_en && hs && !bus.oCmdWr) begin
            bus.iRdValid = 1'b1;
            bus.iRdData  = 8'h5C;
        end

        if (hs) begin
            check_eq("cmd_expected", 64'(exp_cmd.size() > 0), 64'd1);
            if (exp_cmd.size() > 0)
                check_eq("cmd", 64'({bus.oCmdWr, bus.oCmdAddr, bus.oCmdData}), 64'(exp_cmd.pop_front()));
            chk_drop = 1;
            if (bus.oCmdWr) begin
                mem[bus.oCmdAddr] = bus.oCmdData;
            end else begin
                last_hs = cyc;
                if (!(drop_en && bus.oCmdAddr == drop_addr)) begin
                    rd_pending = 1;
                    rd_addr    = bus.oCmdAddr;
                    rd_wait    = (slow_en && bus.oCmdAddr == slow_addr) ? slow_delay : rd_delay;
                end
            end
        end
        if (bus.oRbValid) begin
            check_eq("rb_expected", 64'(exp_rb.size() > 0), 64'd1);
            if (exp_rb.size() > 0)
                check_eq("rb", 64'({bus.oRbAddr, bus.oRbData}), 64'(exp_rb.pop_front()));
        end
    endtask

    task automatic prep_run();
        exp_cmd.delete();
        exp_rb.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ghost = 0;
        rd_pending = 0;
        for (int i = 0; i < int'(N_ENT); i++)
            exp_cmd.push_back({i < int'(WR_CNT), tbl_a[i], (i < int'(WR_CNT)) ? tbl_d[i] : 8'h00});
    endtask

    task automatic run(input int budget, output int lat);
        int t0;
        prep_run();
        start_req = 1;
        step();
        t0 = cyc;
        step();
        check_eq("start_state", {60'd0, bus.oBusy, bus.oDone, bus.oErr, bus.oNo == 8'd0}, {60'd0, 4'b1001});
        while (!(bus.oDone || bus.oErr) && (cyc - t0) < budget) begin
            if (mid_start_en && ((cyc - t0) == 5 || (cyc - t0) == 30)) start_req = 1;
            step();
        end
        lat = cyc - t0;
        check_eq("run_ended", 64'(bus.oDone || bus.oErr), 64'd1);
    endtask

    task automatic check_end(input string tag, input bit done, input bit mism, input int lat, input int exp_lat);
        check_eq({tag, "_flags"}, {60'd0, bus.oDone, bus.oErr, bus.oMismatch, bus.oBusy},
                 {60'd0, done, 1'b0, mism, 1'b0});
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_cmd_left"}, 64'(exp_cmd.size()), 64'd0);
        check_eq({tag, "_rb_left"}, 64'(exp_rb.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return {17'd0, bus.oNo, bus.oCmdValid, bus.oCmdWr, bus.oCmdAddr, bus.oCmdData,
                bus.oRbValid, bus.oRbAddr, bus.oRbData, bus.oBusy, bus.oDone, bus.oErr, bus.oMismatch};
    endfunction

    initial begin
        int lat;
        int t0;
        bus.iStart = 1'b0;   bus.iRegAddr = '0; bus.iRegData = '0;
        bus.iCmdReady = 1'b0; bus.iRdValid = 1'b0; bus.iRdData = '0;

        rst_req = 1; step();
        rst_req = 1; step();
        step();
        check_eq("reset_outs", all_outs(), 64'd0);

        // Plain run, echoing reads.
        run(2000, lat);
        check_end("t1", 1'b1, 1'b0, lat, base_lat(1));

        // MRR of 04 returns a value different from what was written.
        bad_en = 1; bad_addr = 8'h04; bad_data = 8'h47;
        run(2000, lat);
        check_end("t2", 1'b1, 1'b1, lat, base_lat(1));

        // Back-pressure on entry 2; wrong data on an address never written is not a mismatch.
        bad_addr = 8'h02; bad_data = 8'h33;
        hold_en = 1; hold_left = 10;
        run(2000, lat);
        check_end("t3", 1'b1, 1'b0, lat, base_lat(1) + 10);
        check_eq("t3_hold_used", 64'(hold_left), 64'd0);
        hold_en = 0; bad_en = 0;

        // Lost MRR data: WAIT_RD spans counter values 0..RD_TIMEOUT, flag visible one cycle later.
        drop_en = 1; drop_addr = 8'h00;
        run(2000, lat);
        check_eq("t4_err_flags", {61'd0, bus.oErr, bus.oDone, bus.oBusy}, {61'd0, 3'b100});
        check_eq("t4_err_lat", 64'(cyc - last_hs), 64'(RD_TIMEOUT + 2));
        check_eq("t4_cmd_left", 64'(exp_cmd.size()), 64'(N_ENT - WR_CNT - 1));
        check_eq("t4_rb_left", 64'(exp_rb.size()), 64'd0);
        drop_en = 0;
        for (int i = 0; i < 5; i++) step();
        check_eq("t4_err_level", 64'(bus.oErr), 64'd1);
        run(2000, lat);
        check_end("t4_rerun", 1'b1, 1'b0, lat, base_lat(1));

        // Reset while waiting on read data; the late data must not be reported.
        rd_delay = 20;
        prep_run();
        start_req = 1;
        step();
        t0 = cyc;
        while (!rd_pending && (cyc - t0) < 500) step();
        check_eq("t5_reached_wait", 64'(rd_pending), 64'd1);
        rst_req = 1;
        step();
        step();
        check_eq("t5_reset_outs", all_outs(), 64'd0);
        for (int i = 0; i < 30; i++) step();
        check_eq("t5_idle", {62'd0, bus.oBusy, bus.oCmdValid}, 64'd0);
        check_eq("t5_cmd_left", 64'(exp_cmd.size()), 64'(N_ENT - WR_CNT - 1));
        check_eq("t5_rb_left", 64'(exp_rb.size()), 64'd0);
        rd_delay = 1;

        // Stray starts and stray read strobes must not disturb the sequence.
        stray_wr_en = 1; stray_hs_en = 1; mid_start_en = 1;
        run(2000, lat);
        check_end("t6", 1'b1, 1'b0, lat, base_lat(1));
        stray_wr_en = 0; stray_hs_en = 0; mid_start_en = 0;

        // Data arriving on the last counter value before timeout is accepted.
        slow_en = 1; slow_addr = 8'h08; slow_delay = RD_TIMEOUT + 1;
        run(3000, lat);
        check_end("t7", 1'b1, 1'b0, lat, base_lat(1) + RD_TIMEOUT);
        slow_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
